// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
// Shared definitions for the bit-serial adder controller: the controller state
// encoding and its width.
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

    localparam int STATE_W = 2;

    // 2'b11 is deliberately left unused; the controller treats it as illegal
    // and falls back to ST_IDLE on the next edge.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder, purely combinational.
// Ports:
//   x, y   : operand bits
//   c_in   : carry in
//   s_out  : sum bit
//   c_out  : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s_out,
    output logic c_out
);

    logic w_p;

    assign w_p   = x ^ y;
    assign s_out = w_p ^ c_in;
    assign c_out = (x & y) | (c_in & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: one full_adder is time-shared over the WIDTH bits of an
// addition, LSB first, one bit per clock. Operands are captured on an accepted
// start, the adder runs for WIDTH cycles, then the registered sum/carry are
// presented with a one-cycle done pulse. Throughput is one op per WIDTH+2
// cycles.
// Parameters:
//   WIDTH  : operand/sum width (2..32)
//   CNT_W  : bit-counter width, 2**CNT_W >= WIDTH
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   start  : request, sampled only while idle
//   a, b   : operands, captured on accepted start
//   c_in0  : initial carry, captured on accepted start
//   busy   : high while running and during the done cycle
//   done   : one-cycle pulse, sum/c_out valid
//   sum    : registered result, held until the next result
//   c_out  : registered final carry, held until the next result
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;

    logic             w_fa_s;
    logic             w_fa_c;

    // The only arithmetic element: fed from the LSBs of the operand shifters.
    full_adder u_fa (
        .x     (r_a_sh[0]),
        .y     (r_b_sh[0]),
        .c_in  (r_carry),
        .s_out (w_fa_s),
        .c_out (w_fa_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            // Illegal encoding: return to idle without touching the datapath.
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= c_in0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            // Sum bits enter at the MSB so the first (LSB) bit ends at bit 0.
            r_s_sh  <= {w_fa_s, r_s_sh[WIDTH-1:1]};
            r_carry <= w_fa_c;
            r_cnt   <= r_cnt + CNT_W'(1);
            // Last bit is still on the adder output, so assemble it directly.
            if (w_last) begin
                r_sum   <= {w_fa_s, r_s_sh[WIDTH-1:1]};
                r_c_out <= w_fa_c;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=16.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    logic        clk;
    logic        reset;

    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c_in0;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        c_out;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        c16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    int n_checks = 0;
    int n_fail   = 0;
    int starts8  = 0;
    int dones8   = 0;
    int starts16 = 0;
    int dones16  = 0;

    serial_add_ctrl #(.WIDTH(8), .CNT_W(3)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in0 (c_in0),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    serial_add_ctrl #(.WIDTH(16), .CNT_W(4)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .c_in0 (c16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .c_out (cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; called at a negedge with the DUT idle.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic [7:0] es, input logic ec, input string tag,
                         input bit timing);
        int lat;
        int bcnt;
        bit seen;
        a = ia; b = ib; c_in0 = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); c_in0 = 1'($urandom);
        starts8++;
        lat = 0; bcnt = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            if (busy) bcnt++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            dones8++;
            check({tag, "_sum"}, 32'(sum), 32'(es));
            check({tag, "_cout"}, 32'(c_out), 32'(ec));
        end
        @(negedge clk);
        if (timing) begin
            check({tag, "_latency"}, 32'(lat), 32'd8);
            check({tag, "_busy_cycles"}, 32'(bcnt), 32'd9);
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
            check({tag, "_busy_after"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic do_op16(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                           input logic [15:0] es, input logic ec);
        int lat;
        bit seen;
        a16 = ia; b16 = ib; c16 = ic; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        starts16++;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 60) begin
            if (done16) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("rnd16_done_seen", 32'(seen), 32'd1);
        if (seen) begin
            dones16++;
            check("rnd16_latency", 32'(lat), 32'd16);
            check("rnd16_sum", 32'(sum16), 32'(es));
            check("rnd16_cout", 32'(cout16), 32'(ec));
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rc;
        logic [8:0]  e8;
        logic [15:0] wa;
        logic [15:0] wb;
        logic [16:0] e16;
        int dn;
        int waited;

        reset = 1'b1;
        start = 1'b0; a = '0; b = '0; c_in0 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed adds
        do_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, "basic", 1'b1);
        do_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "carry1", 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "carry2", 1'b1);

        // start held high: accepted only every 10 cycles, captured operands used
        dn = 0;
        a = 8'h01; b = 8'h01; c_in0 = 1'b0; start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == 3) begin
                check("hold_prev_sum", 32'(sum), 32'h0FF);
                check("hold_prev_cout", 32'(c_out), 32'd1);
                a = 8'h80;
            end
            if (k == 5) a = 8'h01;
            if (done) begin
                dn++;
                check("hold_done_pos", 32'(k % 10), 32'd9);
                check("hold_sum", 32'(sum), 32'h02);
                check("hold_cout", 32'(c_out), 32'd0);
            end
        end
        check("hold_done_count", 32'(dn), 32'd3);
        start = 1'b0;
        waited = 0;
        while (busy && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("hold_drain", 32'(busy), 32'd0);

        // Reset mid-operation
        a = 8'h12; b = 8'h34; c_in0 = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_running", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(c_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_abort", 1'b1);

        // Random, WIDTH=8
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            e8 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            do_op(ra, rb, rc, e8[7:0], e8[8], "rnd8", 1'b0);
        end
        check("rnd8_done_count", 32'(dones8), 32'(starts8));

        // Random, WIDTH=16
        for (int i = 0; i < 1000; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            rc = 1'($urandom);
            e16 = {1'b0, wa} + {1'b0, wb} + {16'b0, rc};
            do_op16(wa, wb, rc, e16[15:0], e16[16]);
        end
        check("rnd16_done_count", 32'(dones16), 32'(starts16));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
